// File: rtl/uart_pkg.sv
// Shared types and frame constants for the 8N1 UART transmitter and receiver.
package uart_pkg;

    localparam int   DATA_BITS = 8;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        TX_IDLE    = 3'd0,
        TX_START   = 3'd1,
        TX_DATA    = 3'd2,
        TX_STOP    = 3'd3,
        TX_CLEANUP = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE    = 3'd0,
        RX_START   = 3'd1,
        RX_DATA    = 3'd2,
        RX_STOP    = 3'd3,
        RX_CLEANUP = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sampler.sv
// UART receiver: two-flop input synchroniser, mid-bit sampling state machine and
// shift register; publishes a byte with a one-cycle valid pulse on a good stop bit.
module uart_rx_sampler #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_in,
    output logic       rx_dv,
    output logic [7:0] rx_byte
);
    import uart_pkg::*;

    localparam int             CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  CNT_MID  = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0]  CNT_ZERO = CW'(0);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [2:0]     BIT_LAST = 3'(DATA_BITS - 1);

    logic            sync1_q, sync2_q;
    rx_state_t       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      byte_q, byte_d;
    logic            dv_q, dv_d;
    logic            bit_end;

    assign bit_end = (cnt_q == CNT_LAST);

    // Synchroniser flops idle high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= serial_in;
            sync2_q <= sync1_q;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RX_IDLE: begin
                if (sync2_q == START_BIT) state_d = RX_START;
                else                      state_d = RX_IDLE;
            end
            RX_START: begin
                if (cnt_q == CNT_MID) begin
                    if (sync2_q == START_BIT) state_d = RX_DATA;
                    else                      state_d = RX_IDLE;
                end else begin
                    state_d = RX_START;
                end
            end
            RX_DATA: begin
                if (bit_end && (bit_q == BIT_LAST)) state_d = RX_STOP;
                else                                state_d = RX_DATA;
            end
            RX_STOP: begin
                if (bit_end) state_d = RX_CLEANUP;
                else         state_d = RX_STOP;
            end
            RX_CLEANUP: state_d = RX_IDLE;
            default:    state_d = RX_IDLE;
        endcase
    end

    // Counters, shift register and output staging.
    always_comb begin
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        dv_d    = 1'b0;
        case (state_q)
            RX_START: begin
                if (cnt_q == CNT_MID) cnt_d = CNT_ZERO;
                else                  cnt_d = cnt_q + CNT_ONE;
            end
            RX_DATA: begin
                if (bit_end) begin
                    cnt_d          = CNT_ZERO;
                    shift_d[bit_q] = sync2_q;
                    bit_d          = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RX_STOP: begin
                if (bit_end) begin
                    cnt_d = CNT_ZERO;
                    // A low stop bit is a framing error: the byte is dropped.
                    if (sync2_q == STOP_BIT) begin
                        byte_d = shift_q;
                        dv_d   = 1'b1;
                    end else begin
                        byte_d = byte_q;
                        dv_d   = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                cnt_d = CNT_ZERO;
                bit_d = 3'd0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= CNT_ZERO;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            byte_q  <= 8'h00;
            dv_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            dv_q    <= dv_d;
        end
    end

    assign rx_dv   = dv_q;
    assign rx_byte = byte_q;

endmodule

// File: rtl/uart_core.sv
// Full-duplex 8N1 UART: inline transmitter state machine plus the receive sampler.
// Both halves share the clock and the compile-time baud divider but are otherwise independent.
module uart_core #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_TX_DV,
    input  logic [7:0] i_TX_Byte,
    output logic       o_TX_Serial,
    output logic       o_TX_Active,
    output logic       o_TX_Done,
    input  logic       i_RX_Serial,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte
);
    import uart_pkg::*;

    localparam int             CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  CNT_ZERO = CW'(0);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [2:0]     BIT_LAST = 3'(DATA_BITS - 1);

    tx_state_t       tx_state_q, tx_state_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [2:0]      tx_bit_q, tx_bit_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_serial_q, tx_serial_d;
    logic            tx_active_q, tx_active_d;
    logic            tx_done_q, tx_done_d;
    logic            tx_bit_end;

    assign tx_bit_end = (tx_cnt_q == CNT_LAST);

    // State register.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            tx_state_q <= TX_IDLE;
        end else begin
            tx_state_q <= tx_state_d;
        end
    end

    // Next-state logic; strobes outside IDLE are simply ignored.
    always_comb begin
        tx_state_d = tx_state_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (i_TX_DV) tx_state_d = TX_START;
                else         tx_state_d = TX_IDLE;
            end
            TX_START: begin
                if (tx_bit_end) tx_state_d = TX_DATA;
                else            tx_state_d = TX_START;
            end
            TX_DATA: begin
                if (tx_bit_end && (tx_bit_q == BIT_LAST)) tx_state_d = TX_STOP;
                else                                      tx_state_d = TX_DATA;
            end
            TX_STOP: begin
                if (tx_bit_end) tx_state_d = TX_CLEANUP;
                else            tx_state_d = TX_STOP;
            end
            TX_CLEANUP: tx_state_d = TX_IDLE;
            default:    tx_state_d = TX_IDLE;
        endcase
    end

    // Bit-period counter, bit index and byte latch.
    always_comb begin
        tx_cnt_d  = tx_cnt_q;
        tx_bit_d  = tx_bit_q;
        tx_data_d = tx_data_q;
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = CNT_ZERO;
                tx_bit_d = 3'd0;
                if (i_TX_DV) tx_data_d = i_TX_Byte;
                else         tx_data_d = tx_data_q;
            end
            TX_START, TX_STOP: begin
                if (tx_bit_end) tx_cnt_d = CNT_ZERO;
                else            tx_cnt_d = tx_cnt_q + CNT_ONE;
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    tx_cnt_d = CNT_ZERO;
                    tx_bit_d = tx_bit_q + 3'd1;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
            default: begin
                tx_cnt_d = CNT_ZERO;
                tx_bit_d = 3'd0;
            end
        endcase
    end

    // Outputs decode the next state so the registered pins line up with the state register.
    always_comb begin
        tx_serial_d = 1'b1;
        tx_active_d = 1'b0;
        tx_done_d   = 1'b0;
        case (tx_state_d)
            TX_START: begin
                tx_serial_d = START_BIT;
                tx_active_d = 1'b1;
            end
            TX_DATA: begin
                tx_serial_d = tx_data_d[tx_bit_d];
                tx_active_d = 1'b1;
            end
            TX_STOP: begin
                tx_serial_d = STOP_BIT;
                tx_active_d = 1'b1;
            end
            TX_CLEANUP: begin
                tx_serial_d = STOP_BIT;
                tx_done_d   = 1'b1;
            end
            default: begin
                tx_serial_d = 1'b1;
                tx_active_d = 1'b0;
                tx_done_d   = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            tx_cnt_q    <= CNT_ZERO;
            tx_bit_q    <= 3'd0;
            tx_data_q   <= 8'h00;
            tx_serial_q <= 1'b1;
            tx_active_q <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_data_q   <= tx_data_d;
            tx_serial_q <= tx_serial_d;
            tx_active_q <= tx_active_d;
            tx_done_q   <= tx_done_d;
        end
    end

    assign o_TX_Serial = tx_serial_q;
    assign o_TX_Active = tx_active_q;
    assign o_TX_Done   = tx_done_q;

    uart_rx_sampler #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk       (i_Clock),
        .rst       (i_Reset),
        .serial_in (i_RX_Serial),
        .rx_dv     (o_RX_DV),
        .rx_byte   (o_RX_Byte)
    );

endmodule

// File: tb/tb_uart_core.sv
// Scoreboard bench for uart_core: directed TX/RX frames with received bytes checked
// by an independent monitor against a queue of expected bytes.
module tb_uart_core;
    import uart_pkg::*;

    localparam int CPB = 217;

    logic       i_Clock = 1'b0;
    logic       i_Reset;
    logic       i_TX_DV;
    logic [7:0] i_TX_Byte;
    logic       o_TX_Serial;
    logic       o_TX_Active;
    logic       o_TX_Done;
    logic       o_RX_DV;
    logic [7:0] o_RX_Byte;
    logic       loop_en;
    logic       drv_rx;
    logic       rx_line;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         dv_count = 0;
    int         n_pushed = 0;
    logic [7:0] exp_q[$];
    logic [7:0] last_good = 8'h00;

    assign rx_line = loop_en ? o_TX_Serial : drv_rx;

    always #20 i_Clock = ~i_Clock;

    uart_core #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock     (i_Clock),
        .i_Reset     (i_Reset),
        .i_TX_DV     (i_TX_DV),
        .i_TX_Byte   (i_TX_Byte),
        .o_TX_Serial (o_TX_Serial),
        .o_TX_Active (o_TX_Active),
        .o_TX_Done   (o_TX_Done),
        .i_RX_Serial (rx_line),
        .o_RX_DV     (o_RX_DV),
        .o_RX_Byte   (o_RX_Byte)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_rx(input logic [7:0] b);
        exp_q.push_back(b);
        last_good = b;
        n_pushed++;
    endtask

    task automatic strobe(input logic [7:0] b);
        @(posedge i_Clock); #1;
        i_TX_Byte = b;
        i_TX_DV   = 1'b1;
        @(posedge i_Clock); #1;
        i_TX_DV   = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        do begin
            @(negedge i_Clock);
            n++;
        end while ((o_TX_Done !== 1'b1) && (n < 3000));
        check(name, o_TX_Done, 1);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0) && (n < 3000)) begin
            @(negedge i_Clock);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        @(posedge i_Clock); #1;
        for (int k = 0; k < 10; k++) begin
            drv_rx = bits[k];
            repeat (CPB) @(posedge i_Clock);
            #1;
        end
        drv_rx = 1'b1;
    endtask

    // Monitor: every DV pulse must match the oldest expected byte.
    initial begin
        forever begin
            @(negedge i_Clock);
            if (o_RX_DV === 1'b1) begin
                dv_count++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rx_unexpected_dv: got DV with byte 0x%0h, required no DV", o_RX_Byte);
                end else begin
                    check("rx_byte", o_RX_Byte, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int act_cnt;
        int pos;
        int done_seen;
        logic [9:0] exp_bits;
        logic [7:0] b2b [3];

        i_Reset   = 1'b1;
        i_TX_DV   = 1'b0;
        i_TX_Byte = 8'h00;
        loop_en   = 1'b1;
        drv_rx    = 1'b1;
        repeat (3) @(posedge i_Clock);
        @(negedge i_Clock);
        check("reset_tx_serial", o_TX_Serial, 1);
        check("reset_tx_active", o_TX_Active, 0);
        check("reset_tx_done",   o_TX_Done,   0);
        check("reset_rx_dv",     o_RX_DV,     0);
        check("reset_rx_byte",   o_RX_Byte,   8'h00);
        @(posedge i_Clock); #1;
        i_Reset = 1'b0;

        // Loopback 0x6B with latency and active-length checks.
        expect_rx(8'h6B);
        strobe(8'h6B);
        @(negedge i_Clock);
        check("tx_latency_serial", o_TX_Serial, 0);
        check("tx_latency_active", o_TX_Active, 1);
        act_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            if (o_TX_Active !== 1'b1) break;
            act_cnt++;
            @(negedge i_Clock);
        end
        check("tx_active_cycles", act_cnt, 2170);
        check("tx_done_pulse", o_TX_Done, 1);
        check("tx_done_active_low", o_TX_Active, 0);
        @(negedge i_Clock);
        check("tx_done_width", o_TX_Done, 0);
        wait_drain("rx_loopback_6b");

        // Bit order of 0x01 at each mid-bit.
        exp_bits = 10'b10_0000_0010;
        expect_rx(8'h01);
        strobe(8'h01);
        @(negedge i_Clock);
        pos = 0;
        for (int k = 0; k < 10; k++) begin
            while (pos < (k * CPB + CPB / 2)) begin
                @(negedge i_Clock);
                pos++;
            end
            check($sformatf("tx_bit_%0d", k), o_TX_Serial, exp_bits[k]);
        end
        wait_done("bitorder_done");
        wait_drain("rx_bitorder");

        // Back-to-back frames, each strobe right after the previous Done.
        b2b[0] = 8'h00;
        b2b[1] = 8'hFF;
        b2b[2] = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            expect_rx(b2b[i]);
            strobe(b2b[i]);
            @(negedge i_Clock);
            check($sformatf("b2b_accept_%0d", i), o_TX_Active, 1);
            wait_done($sformatf("b2b_done_%0d", i));
        end
        wait_drain("rx_b2b");

        // Strobe while busy must be dropped.
        expect_rx(8'hC3);
        strobe(8'hC3);
        repeat (700) @(negedge i_Clock);
        strobe(8'h55);
        wait_done("busy_done");
        repeat (2500) @(negedge i_Clock);
        check("busy_no_extra_frame", o_TX_Active, 0);
        wait_drain("rx_busy");
        check("busy_rx_byte", o_RX_Byte, 8'hC3);

        // Short low glitch is a false start.
        loop_en = 1'b0;
        @(posedge i_Clock); #1;
        drv_rx = 1'b0;
        repeat (50) @(posedge i_Clock);
        #1;
        drv_rx = 1'b1;
        repeat (400) @(negedge i_Clock);
        check("false_start_idle", dut.u_rx.state_q, RX_IDLE);
        check("false_start_byte", o_RX_Byte, last_good);

        // Good bench-driven frame, then one with a low stop bit.
        expect_rx(8'h5A);
        drive_frame(8'h5A, 1'b1);
        wait_drain("rx_driven_5a");
        drive_frame(8'h99, 1'b0);
        repeat (3000) @(negedge i_Clock);
        check("framing_err_byte", o_RX_Byte, 8'h5A);
        check("framing_err_idle", dut.u_rx.state_q, RX_IDLE);

        // Reset during data bit 4 of a loopback frame.
        loop_en = 1'b1;
        strobe(8'h00);
        @(negedge i_Clock);
        repeat (5 * CPB + 100) @(negedge i_Clock);
        @(posedge i_Clock); #1;
        i_Reset = 1'b1;
        @(posedge i_Clock); #1;
        i_Reset = 1'b0;
        @(negedge i_Clock);
        check("midreset_serial", o_TX_Serial, 1);
        check("midreset_active", o_TX_Active, 0);
        check("midreset_done",   o_TX_Done,   0);
        done_seen = 0;
        repeat (2500) begin
            @(negedge i_Clock);
            if (o_TX_Done === 1'b1) done_seen = 1;
        end
        check("midreset_no_done", done_seen, 0);
        check("midreset_rx_byte", o_RX_Byte, 8'h00);

        // Transfer after reset.
        expect_rx(8'h3C);
        strobe(8'h3C);
        wait_done("post_reset_done");
        wait_drain("rx_post_reset_3c");

        check("dv_pulse_count", dv_count, n_pushed);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
